// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//   Sequences a multi-cycle MIPS datapath (IF/ID/EX/MEM/WB) that shares one
//   memory port and one ALU between instruction fetch and data access.
//   Memory latency is variable: FETCH, MEM_RD and MEM_WR hold their request
//   until mem_ready. Counts retired instructions. An unsupported opcode parks
//   the machine in HALT with a sticky illegal flag until reset.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   opcode[5:0]           instruction[31:26] from the instruction register
//   zero                  ALU zero flag, meaningful in BRANCH
//   mem_ready             memory completes the access this cycle
//   pc_en ... pc_source   datapath control (see state table below)
//   illegal               sticky unsupported-opcode flag
//   state[3:0]            current state encoding (debug)
//   retired[CNT_W-1:0]    completed-instruction counter, wraps
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             reg_dest,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    state_t cur;

    assign state = cur;

    // State, retire counter and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            unique case (cur)
                S_FETCH:    if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_LW || opcode == OP_SW) cur <= S_MEM_ADDR;
                    else if (opcode == OP_RTYPE)            cur <= S_R_EXEC;
                    else if (opcode == OP_BEQ)              cur <= S_BRANCH;
                    else if (opcode == OP_J)                cur <= S_JUMP;
                    else if (opcode == OP_ADDI)             cur <= S_ADDI_EXEC;
                    else begin
                        cur     <= S_HALT;
                        illegal <= 1'b1;
                    end
                end
                S_MEM_ADDR: cur <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) cur <= S_MEM_WB;
                S_MEM_WR: begin
                    if (mem_ready) begin
                        cur     <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                S_R_EXEC:    cur <= S_R_WB;
                S_ADDI_EXEC: cur <= S_ADDI_WB;
                S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                    cur     <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                S_HALT:  cur <= S_HALT;
                default: cur <= S_FETCH;
            endcase
        end
    end

    // Control decode. Kept combinational from the state register because
    // ir_write/pc_en/mdr_write must track mem_ready and pc_en must track zero
    // in the same cycle. Gated by reset so nothing writes in a reset cycle.
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_source  = 2'd0;
        if (!reset) begin
            unique case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;          // PC + 4
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE:   alu_src_b = 2'd3;  // branch target precompute
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEM_RD: begin
                    mem_read  = 1'b1;
                    i_or_d    = 1'b1;
                    mdr_write = mem_ready;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dest  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd1;
                    pc_source = 2'd1;
                    pc_en     = zero;
                end
                S_JUMP: begin
                    pc_source = 2'd2;
                    pc_en     = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_ADDI_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int CW = 4;   // small counter so wraparound is exercised

    // spec state numbers
    localparam logic [3:0] P_F = 4'd0, P_D = 4'd1, P_MA = 4'd2, P_MR = 4'd3,
                           P_MWB = 4'd4, P_MW = 4'd5, P_RE = 4'd6, P_RW = 4'd7,
                           P_BR = 4'd8, P_J = 4'd9, P_AE = 4'd10, P_AW = 4'd11,
                           P_H = 4'd12;

    typedef struct packed {
        logic pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write;
        logic reg_dest, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
    } ctrl_t;

    typedef struct {
        logic       full;
        logic [3:0] st;
        ctrl_t      c;
        int         ret;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [3:0] ph;
        logic       rdy;
        logic       z;
    } step_t;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write;
    logic reg_dest, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [CW-1:0] retired;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    ctrl_t act;
    assign act = '{pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write,
                   reg_dest, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source};

    exp_t  sb[$];
    step_t plan[$];
    int    total = 0, bad = 0;
    int    model_cnt = 0;
    logic  model_ill = 1'b0;

    // Control table per phase, written straight from the state descriptions.
    function automatic ctrl_t ctrl_of(logic [3:0] ph, logic rdy, logic z);
        ctrl_t c = '0;
        case (ph)
            P_F:   begin c.mem_read = 1; c.alu_src_b = 1; c.ir_write = rdy; c.pc_en = rdy; end
            P_D:   c.alu_src_b = 3;
            P_MA:  begin c.alu_src_a = 1; c.alu_src_b = 2; end
            P_MR:  begin c.mem_read = 1; c.i_or_d = 1; c.mdr_write = rdy; end
            P_MWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
            P_MW:  begin c.mem_write = 1; c.i_or_d = 1; end
            P_RE:  begin c.alu_src_a = 1; c.alu_op = 2; end
            P_RW:  begin c.reg_write = 1; c.reg_dest = 1; end
            P_BR:  begin c.alu_src_a = 1; c.alu_op = 1; c.pc_source = 1; c.pc_en = z; end
            P_J:   begin c.pc_source = 2; c.pc_en = 1; end
            P_AE:  begin c.alu_src_a = 1; c.alu_src_b = 2; end
            P_AW:  c.reg_write = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B ||
               op == 6'h04 || op == 6'h02 || op == 6'h08;
    endfunction

    // Monitor: one expected record per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (act !== e.c) begin
                bad++;
                $display("FAIL ctrl t=%0t got=%h exp=%h st=%0d", $time, act, e.c, state);
            end
            if (e.full) begin
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e.st);
                end
                total++;
                if (retired !== CW'(e.ret)) begin
                    bad++;
                    $display("FAIL retired t=%0t got=%0d exp=%0d", $time, retired, CW'(e.ret));
                end
                total++;
                if (illegal !== e.ill) begin
                    bad++;
                    $display("FAIL illegal t=%0t got=%0b exp=%0b", $time, illegal, e.ill);
                end
            end
        end
    end

    task automatic do_cycle(input logic rst, input logic [5:0] op,
                            input logic rdy, input logic z, input logic [3:0] ph);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; opcode = op; mem_ready = rdy; zero = z;
        e.full = !rst;
        e.st   = ph;
        e.c    = rst ? ctrl_t'('0) : ctrl_of(ph, rdy, z);
        e.ret  = model_cnt % (1 << CW);
        e.ill  = model_ill;
        sb.push_back(e);
        if (rst) begin
            model_cnt = 0;
            model_ill = 1'b0;
        end
    endtask

    task automatic push_step(input logic [3:0] ph, input logic rdy, input logic z);
        step_t s;
        s.ph = ph; s.rdy = rdy; s.z = z;
        plan.push_back(s);
    endtask

    task automatic push_wait(input logic [3:0] ph, input int w);
        for (int i = 0; i < w; i++) push_step(ph, 1'b0, 1'($urandom));
        push_step(ph, 1'b1, 1'($urandom));
    endtask

    // One instruction as the sequence of phases it must walk through.
    task automatic build_plan(input logic [5:0] op, input int fw, input int mw, input logic z);
        plan.delete();
        push_wait(P_F, fw);
        push_step(P_D, 1'($urandom), 1'($urandom));
        case (op)
            6'h23: begin push_step(P_MA, 1'($urandom), 1'($urandom)); push_wait(P_MR, mw);
                         push_step(P_MWB, 1'($urandom), 1'($urandom)); end
            6'h2B: begin push_step(P_MA, 1'($urandom), 1'($urandom)); push_wait(P_MW, mw); end
            6'h00: begin push_step(P_RE, 1'($urandom), 1'($urandom));
                         push_step(P_RW, 1'($urandom), 1'($urandom)); end
            6'h08: begin push_step(P_AE, 1'($urandom), 1'($urandom));
                         push_step(P_AW, 1'($urandom), 1'($urandom)); end
            6'h04: push_step(P_BR, 1'($urandom), z);
            6'h02: push_step(P_J, 1'($urandom), 1'($urandom));
            default: for (int i = 0; i < 3; i++) push_step(P_H, 1'($urandom), 1'($urandom));
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic z, input int abort_at);
        build_plan(op, fw, mw, z);
        for (int i = 0; i < plan.size(); i++) begin
            if (i == abort_at) begin
                do_cycle(1'b1, op, plan[i].rdy, plan[i].z, plan[i].ph);
                return;
            end
            // IR is not loaded yet during fetch: opcode bus carries junk
            do_cycle(1'b0, (plan[i].ph == P_F) ? 6'($urandom) : op,
                     plan[i].rdy, plan[i].z, plan[i].ph);
            if (plan[i].ph == P_D && !is_legal(op)) model_ill = 1'b1;
        end
        if (is_legal(op)) model_cnt++;
        else do_cycle(1'b1, op, 1'b0, 1'b0, P_F);
    endtask

    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    initial begin
        do_cycle(1'b1, 6'h00, 1'b0, 1'b0, P_F);
        do_cycle(1'b1, 6'h00, 1'b1, 1'b1, P_F);
        run_instr(6'h23, 0, 0, 1'b0, -1);     // LW, ready tied high: 5 cycles
        run_instr(6'h2B, 0, 3, 1'b0, -1);     // SW, 3 wait cycles in MEM_WR
        run_instr(6'h04, 0, 0, 1'b1, -1);     // BEQ taken
        run_instr(6'h04, 0, 0, 1'b0, -1);     // BEQ not taken
        run_instr(6'h00, 5, 0, 1'b0, -1);     // R-type with slow fetch
        run_instr(6'h02, 0, 0, 1'b0, -1);
        run_instr(6'h08, 1, 0, 1'b0, -1);
        run_instr(6'h00, 0, 0, 1'b0, 2);      // reset lands in R_EXEC
        run_instr(6'h08, 0, 0, 1'b0, -1);
        run_instr(6'h3F, 0, 0, 1'b0, -1);     // illegal -> HALT, then reset
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int fw, mw, ab;
            op = ($urandom_range(0, 19) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            ab = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(op, fw, mw, 1'($urandom), ab);
        end
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
